// File: rtl/interface_tag_rob.sv
// Tag-pool request interface with an in-order reorder buffer for OpenCAPI read responses.
// Optional: define INTERFACE_TAG_ROB_ERR_EN to drop stray responses and flag a sticky o_err.
module interface_tag_rob #(
  parameter int addr_width = 64,
  parameter int data_width = 1024,
  parameter int nstrms = 64,
  parameter int ntags = 16,
  parameter int l2_ncl = 256,
  localparam int nstrms_width = $clog2(nstrms),
  localparam int tag_width = $clog2(ntags),
  localparam int l2_ncl_width = $clog2(l2_ncl)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req_v,
  output logic                    i_req_r,
  input  logic [nstrms_width-1:0] i_req_sid,
  input  logic [l2_ncl_width-1:0] i_req_ptr,
  input  logic [addr_width-1:0]   i_req_ea,
  output logic                    o_req_v,
  input  logic                    o_req_r,
  output logic [addr_width-1:0]   o_req_ea,
  output logic [tag_width-1:0]    o_req_tag,
  input  logic                    i_rsp_v,
  output logic                    i_rsp_r,
  input  logic [tag_width-1:0]    i_rsp_tag,
  input  logic [data_width-1:0]   i_rsp_data,
  output logic                    o_rsp_v,
  input  logic                    o_rsp_r,
  output logic [data_width-1:0]   o_rsp_data,
  output logic [nstrms_width-1:0] o_rsp_sid,
  output logic [l2_ncl_width-1:0] o_rsp_ptr,
  output logic [tag_width:0]      o_cnt,
  output logic                    o_err
);

  localparam logic [tag_width:0] cnt_full = (tag_width+1)'(ntags);
  localparam logic [tag_width:0] ptr_one = (tag_width+1)'(1);

  logic [tag_width:0]      head, tail;
  logic [ntags-1:0]        valid_q, done_q;
  logic [nstrms_width-1:0] sid_q [ntags];
  logic [l2_ncl_width-1:0] ptr_q [ntags];
  logic [data_width-1:0]   data_q [ntags];

  logic [tag_width-1:0] head_idx, tail_idx;
  logic accept, retire, rsp_ok, rsp_wr;

  assign head_idx = head[tag_width-1:0];
  assign tail_idx = tail[tag_width-1:0];

  // Wrap bit in the MSB lets head - tail reach ntags without ambiguity.
  assign o_cnt   = head - tail;
  assign i_req_r = (o_cnt < cnt_full) && (!o_req_v || o_req_r);
  assign i_rsp_r = 1'b1;

  assign accept = i_req_v && i_req_r;
  assign o_rsp_v = valid_q[tail_idx] && done_q[tail_idx];
  assign retire = o_rsp_v && o_rsp_r;
  assign rsp_ok = valid_q[i_rsp_tag] && !done_q[i_rsp_tag];

  assign o_rsp_data = data_q[tail_idx];
  assign o_rsp_sid  = sid_q[tail_idx];
  assign o_rsp_ptr  = ptr_q[tail_idx];

`ifdef INTERFACE_TAG_ROB_ERR_EN
  logic err_q;

  assign rsp_wr = i_rsp_v && rsp_ok;
  assign o_err  = err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (i_rsp_v && !rsp_ok) begin
      err_q <= 1'b1;
    end
  end
`else
  logic unused_rsp_ok;

  assign unused_rsp_ok = rsp_ok;
  assign rsp_wr = i_rsp_v;
  assign o_err  = 1'b0;
`endif

  // Later assignments win: an accept re-arms its slot after any stale response write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head      <= '0;
      tail      <= '0;
      valid_q   <= '0;
      done_q    <= '0;
      o_req_v   <= 1'b0;
      o_req_ea  <= '0;
      o_req_tag <= '0;
      for (int i = 0; i < ntags; i++) begin
        sid_q[i]  <= '0;
        ptr_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (retire) begin
        valid_q[tail_idx] <= 1'b0;
        done_q[tail_idx]  <= 1'b0;
        tail              <= tail + ptr_one;
      end
      if (rsp_wr) begin
        data_q[i_rsp_tag] <= i_rsp_data;
        done_q[i_rsp_tag] <= 1'b1;
      end
      if (accept) begin
        valid_q[head_idx] <= 1'b1;
        done_q[head_idx]  <= 1'b0;
        sid_q[head_idx]   <= i_req_sid;
        ptr_q[head_idx]   <= i_req_ptr;
        head              <= head + ptr_one;
        o_req_v           <= 1'b1;
        o_req_ea          <= i_req_ea;
        o_req_tag         <= head_idx;
      end else if (o_req_r) begin
        o_req_v <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_interface_tag_rob.sv
// Scoreboard bench for interface_tag_rob: directed scenarios plus randomized traffic vs. a queue model.
module tb_interface_tag_rob;

  localparam int aw = 64;
  localparam int dw = 64;
  localparam int nt = 4;
  localparam int tw = 2;
  localparam int sw = 6;
  localparam int pw = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic i_req_v = 1'b0, i_req_r;
  logic [sw-1:0] i_req_sid = '0;
  logic [pw-1:0] i_req_ptr = '0;
  logic [aw-1:0] i_req_ea = '0;
  logic o_req_v, o_req_r = 1'b0;
  logic [aw-1:0] o_req_ea;
  logic [tw-1:0] o_req_tag;
  logic i_rsp_v = 1'b0, i_rsp_r;
  logic [tw-1:0] i_rsp_tag = '0;
  logic [dw-1:0] i_rsp_data = '0;
  logic o_rsp_v, o_rsp_r = 1'b0;
  logic [dw-1:0] o_rsp_data;
  logic [sw-1:0] o_rsp_sid;
  logic [pw-1:0] o_rsp_ptr;
  logic [tw:0] o_cnt;
  logic o_err;

  interface_tag_rob #(
    .addr_width(aw), .data_width(dw), .nstrms(64), .ntags(nt), .l2_ncl(256)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_v(i_req_v), .i_req_r(i_req_r), .i_req_sid(i_req_sid),
    .i_req_ptr(i_req_ptr), .i_req_ea(i_req_ea),
    .o_req_v(o_req_v), .o_req_r(o_req_r), .o_req_ea(o_req_ea), .o_req_tag(o_req_tag),
    .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_tag(i_rsp_tag), .i_rsp_data(i_rsp_data),
    .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r), .o_rsp_data(o_rsp_data),
    .o_rsp_sid(o_rsp_sid), .o_rsp_ptr(o_rsp_ptr), .o_cnt(o_cnt), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  typedef struct packed {
    logic [tw-1:0] tag;
    logic [sw-1:0] sid;
    logic [pw-1:0] ptr;
  } rob_entry_t;

  // Reference model: accepted-but-unretired entries in issue order, plus per-tag response store.
  rob_entry_t rob_q[$];
  bit got [nt];
  logic [dw-1:0] rsp_mem [nt];
  bit pend;
  logic [aw-1:0] pend_ea;
  logic [tw-1:0] pend_tag;
  int acc_count;
  int unanswered[$];
  bit err_exp;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  function automatic bit inRob(input logic [tw-1:0] tag);
    foreach (rob_q[i]) if (rob_q[i].tag == tag) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: compares mid-cycle, then advances the model for the coming rising edge.
  always @(negedge clk) begin
    bit exp_ireq_r, exp_rsp_v, acc, ret, issue, rsp_take;
    if (!reset) begin
      rob_q.delete();
      unanswered.delete();
      foreach (got[i]) got[i] = 1'b0;
      pend = 1'b0;
      acc_count = 0;
      err_exp = 1'b0;
    end else begin
      exp_ireq_r = (rob_q.size() < nt) && (!pend || o_req_r);
      exp_rsp_v = (rob_q.size() > 0) && got[rob_q[0].tag];
      checkOutput("i_req_r", 64'(i_req_r), 64'(exp_ireq_r));
      checkOutput("o_req_v", 64'(o_req_v), 64'(pend));
      if (pend) begin
        checkOutput("o_req_ea", o_req_ea, pend_ea);
        checkOutput("o_req_tag", 64'(o_req_tag), 64'(pend_tag));
      end
      checkOutput("o_rsp_v", 64'(o_rsp_v), 64'(exp_rsp_v));
      if (exp_rsp_v) begin
        checkOutput("o_rsp_data", o_rsp_data, rsp_mem[rob_q[0].tag]);
        checkOutput("o_rsp_sid", 64'(o_rsp_sid), 64'(rob_q[0].sid));
        checkOutput("o_rsp_ptr", 64'(o_rsp_ptr), 64'(rob_q[0].ptr));
      end
      checkOutput("o_cnt", 64'(o_cnt), 64'(rob_q.size()));
      checkOutput("o_err", 64'(o_err), 64'(err_exp));
      checkOutput("i_rsp_r", 64'(i_rsp_r), 64'd1);

      acc = i_req_v && exp_ireq_r;
      ret = exp_rsp_v && o_rsp_r;
      issue = pend && o_req_r;
      if (ret) begin
        got[rob_q[0].tag] = 1'b0;
        void'(rob_q.pop_front());
      end
      if (i_rsp_v) begin
`ifdef INTERFACE_TAG_ROB_ERR_EN
        rsp_take = inRob(i_rsp_tag) && !got[i_rsp_tag];
        if (!rsp_take) err_exp = 1'b1;
`else
        rsp_take = 1'b1;
`endif
        if (rsp_take) begin
          got[i_rsp_tag] = 1'b1;
          rsp_mem[i_rsp_tag] = i_rsp_data;
        end
      end
      if (issue) begin
        pend = 1'b0;
        unanswered.push_back(int'(pend_tag));
      end
      if (acc) begin
        pend = 1'b1;
        pend_ea = i_req_ea;
        pend_tag = tw'(acc_count % nt);
        rob_q.push_back('{tag: tw'(acc_count % nt), sid: i_req_sid, ptr: i_req_ptr});
        got[acc_count % nt] = 1'b0;
        acc_count++;
      end
    end
  end

  // One cycle of inputs; returns 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rv, input logic [sw-1:0] sid, input logic [pw-1:0] ptr,
                               input logic [aw-1:0] ea, input logic orr, input logic sv,
                               input logic [tw-1:0] tag, input logic [dw-1:0] data, input logic osr);
    i_req_v = rv; i_req_sid = sid; i_req_ptr = ptr; i_req_ea = ea; o_req_r = orr;
    i_rsp_v = sv; i_rsp_tag = tag; i_rsp_data = data; o_rsp_r = osr;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic randomCycle(input bit allow_req);
    logic sv;
    logic [tw-1:0] tag;
    sv = 1'b0;
    tag = '0;
    if (unanswered.size() > 0 && ($urandom % 2 == 0 || !allow_req)) begin
      int idx;
      idx = int'($urandom_range(0, unanswered.size() - 1));
      tag = tw'(unanswered[idx]);
      unanswered.delete(idx);
      sv = 1'b1;
    end
    applyStimulus(allow_req && ($urandom % 2 == 0), sw'($urandom), pw'($urandom), {$urandom, $urandom},
                  allow_req ? ($urandom % 4 != 0) : 1'b1, sv, tag, {$urandom, $urandom},
                  allow_req ? ($urandom % 4 != 0) : 1'b1);
  endtask

  initial begin
    // Reset values while reset is held low.
    @(posedge clk);
    #1;
    checkOutput("rst_i_req_r", 64'(i_req_r), 64'd1);
    checkOutput("rst_o_req_v", 64'(o_req_v), 64'd0);
    checkOutput("rst_o_req_ea", o_req_ea, 64'd0);
    checkOutput("rst_o_req_tag", 64'(o_req_tag), 64'd0);
    checkOutput("rst_i_rsp_r", 64'(i_rsp_r), 64'd1);
    checkOutput("rst_o_rsp_v", 64'(o_rsp_v), 64'd0);
    checkOutput("rst_o_rsp_data", o_rsp_data, 64'd0);
    checkOutput("rst_o_rsp_sid", 64'(o_rsp_sid), 64'd0);
    checkOutput("rst_o_rsp_ptr", 64'(o_rsp_ptr), 64'd0);
    checkOutput("rst_o_cnt", 64'(o_cnt), 64'd0);
    checkOutput("rst_o_err", 64'(o_err), 64'd0);
    reset = 1'b1;

    $display("[TB] single request/response");
    applyStimulus(1, 1, 5, 64'h2, 1, 0, 0, 0, 1);
    checkOutput("t1_req_tag", 64'(o_req_tag), 64'd0);
    checkOutput("t1_req_ea", o_req_ea, 64'h2);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 64'hAB, 1);
    checkOutput("t1_rsp_v", 64'(o_rsp_v), 64'd1);
    checkOutput("t1_rsp_data", o_rsp_data, 64'hAB);
    checkOutput("t1_cnt_before", 64'(o_cnt), 64'd1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
    checkOutput("t1_cnt_after", 64'(o_cnt), 64'd0);

    $display("[TB] out-of-order responses");
    doReset();
    applyStimulus(1, 2, 10, 64'h4, 1, 0, 0, 0, 1);
    applyStimulus(1, 3, 11, 64'h5, 1, 0, 0, 0, 1);
    applyStimulus(1, 4, 12, 64'h6, 1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 2, 64'h66, 1);
    checkOutput("t2_hold", 64'(o_rsp_v), 64'd0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 64'h44, 1);
    checkOutput("t2_first_sid", 64'(o_rsp_sid), 64'd2);
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 64'h55, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
    checkOutput("t2_drained", 64'(o_cnt), 64'd0);

    $display("[TB] full pool");
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1, sw'(i), pw'(i), 64'h100 + 64'(i), 1, 0, 0, 0, 1);
    checkOutput("t3_full_ready", 64'(i_req_r), 64'd0);
    checkOutput("t3_full_cnt", 64'(o_cnt), 64'd4);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 64'h77, 1);
    checkOutput("t3_ready_on_retire", 64'(i_req_r), 64'd0);
    applyStimulus(1, 9, 9, 64'h200, 1, 0, 0, 0, 1);
    checkOutput("t3_ready_after", 64'(i_req_r), 64'd1);
    applyStimulus(1, 9, 9, 64'h200, 1, 0, 0, 0, 1);
    checkOutput("t3_fifth_v", 64'(o_req_v), 64'd1);
    checkOutput("t3_fifth_tag", 64'(o_req_tag), 64'd0);

    $display("[TB] OpenCAPI backpressure");
    doReset();
    applyStimulus(1, 7, 7, 64'h300, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 8, 8, 64'h301, 0, 0, 0, 0, 0);
    checkOutput("t4_cnt", 64'(o_cnt), 64'd1);
    checkOutput("t4_ea", o_req_ea, 64'h300);
    checkOutput("t4_tag", 64'(o_req_tag), 64'd0);
    applyStimulus(1, 8, 8, 64'h301, 1, 0, 0, 0, 0);
    checkOutput("t4_next_tag", 64'(o_req_tag), 64'd1);

    $display("[TB] response to idle tag");
    doReset();
    applyStimulus(0, 0, 0, 0, 1, 1, 3, 64'hEE, 1);
`ifdef INTERFACE_TAG_ROB_ERR_EN
    checkOutput("t6_err", 64'(o_err), 64'd1);
`else
    checkOutput("t6_err", 64'(o_err), 64'd0);
`endif
    checkOutput("t6_no_rsp", 64'(o_rsp_v), 64'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 1);
`ifdef INTERFACE_TAG_ROB_ERR_EN
    checkOutput("t6_err_sticky", 64'(o_err), 64'd1);
`else
    checkOutput("t6_err_sticky", 64'(o_err), 64'd0);
`endif

    $display("[TB] randomized traffic");
    doReset();
    for (int i = 0; i < 400; i++) randomCycle(1'b1);
    for (int i = 0; i < 200 && (rob_q.size() > 0 || pend); i++) randomCycle(1'b0);
    checkOutput("drain_model_empty", 64'(rob_q.size()), 64'd0);
    checkOutput("drain_cnt", 64'(o_cnt), 64'd0);
    checkOutput("wrap_progress", 64'(acc_count >= 20), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
